// File: rtl/psum_drain_4x1_if.sv
// Output stream from the partial-sum drain toward the output feature-map buffer.
// The master drives one quantized result per handshake, tagged with its row index.
interface psum_drain_4x1_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_row;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_row,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_drain_4x1.sv
// Captures four skewed column partial sums, requantizes them (bias, ReLU, shift,
// saturate) into a 4-entry bank, and streams the bank out over a valid/ready link.
module psum_drain_4x1 #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    capture_i,
    input  logic signed [ACC_W-1:0] bias_i,
    input  logic [SHIFT_W-1:0]      shift_i,
    input  logic signed [ACC_W-1:0] after_sum_1,
    input  logic signed [ACC_W-1:0] after_sum_2,
    input  logic signed [ACC_W-1:0] after_sum_3,
    input  logic signed [ACC_W-1:0] after_sum_4,
    input  logic                    clr_err_i,
    output logic                    busy,
    output logic                    overrun,
    psum_drain_4x1_if.master        ob
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [ACC_W:0] SAT = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // The sum is widened by one bit so that bias addition can never wrap.
    function automatic logic [OUT_W-1:0] quant(
        input logic signed [ACC_W-1:0] s,
        input logic signed [ACC_W-1:0] b,
        input logic [SHIFT_W-1:0]      sh
    );
        logic [ACC_W:0] t;
        logic [ACC_W:0] u;
        t = {s[ACC_W-1], s} + {b[ACC_W-1], b};
        u = t >> sh;
        if (t[ACC_W]) begin
            quant = '0;
        end else if (u > SAT) begin
            quant = '1;
        end else begin
            quant = u[OUT_W-1:0];
        end
    endfunction

    state_t                    state;
    logic [1:0]                cnt;
    logic [1:0]                rd_ptr;
    logic [1:0]                rd_nxt;
    logic signed [ACC_W-1:0]   bias_r;
    logic [SHIFT_W-1:0]        shift_r;
    logic [OUT_W-1:0]          bank [4];
    logic signed [ACC_W-1:0]   cap_sum;
    logic [OUT_W-1:0]          q_first;
    logic [OUT_W-1:0]          q_row;
    logic                      handshake;

    logic [OUT_W-1:0]          out_data_r;
    logic [1:0]                out_row_r;
    logic                      out_valid_r;
    logic                      out_last_r;

    always_comb begin
        cap_sum = after_sum_4;
        unique case (cnt)
            2'd1:    cap_sum = after_sum_2;
            2'd2:    cap_sum = after_sum_3;
            default: cap_sum = after_sum_4;
        endcase
    end

    // Row 1 is quantized with the bias/shift arriving alongside the capture pulse,
    // later rows with the copies latched at that pulse.
    assign q_first   = quant(after_sum_1, bias_i, shift_i);
    assign q_row     = quant(cap_sum, bias_r, shift_r);
    assign handshake = out_valid_r & ob.out_ready;
    assign rd_nxt    = rd_ptr + 2'd1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            rd_ptr      <= 2'd0;
            bias_r      <= '0;
            shift_r     <= '0;
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
            out_data_r  <= '0;
            out_row_r   <= 2'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (capture_i && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_err_i) begin
                overrun <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (capture_i) begin
                        bias_r  <= bias_i;
                        shift_r <= shift_i;
                        bank[0] <= q_first;
                        cnt     <= 2'd1;
                        busy    <= 1'b1;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bank[cnt] <= q_row;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        rd_ptr      <= 2'd0;
                        out_data_r  <= bank[0];
                        out_row_r   <= 2'd0;
                        out_last_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (rd_ptr == 2'd3) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            rd_ptr     <= rd_nxt;
                            out_data_r <= bank[rd_nxt];
                            out_row_r  <= rd_nxt;
                            out_last_r <= (rd_nxt == 2'd3);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ob.out_data  = out_data_r;
    assign ob.out_row   = out_row_r;
    assign ob.out_valid = out_valid_r;
    assign ob.out_last  = out_last_r;

endmodule

// File: tb/tb_psum_drain_4x1.sv
// Scoreboard bench for psum_drain_4x1: capture tasks queue hand-computed results,
// an independent monitor pops them on every output handshake and checks stalls.
module tb_psum_drain_4x1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] row;
        logic       last;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RSTN;
    logic               capture_i;
    logic signed [31:0] bias_i;
    logic [4:0]         shift_i;
    logic signed [31:0] after_sum_1;
    logic signed [31:0] after_sum_2;
    logic signed [31:0] after_sum_3;
    logic signed [31:0] after_sum_4;
    logic               clr_err_i;
    logic               busy;
    logic               overrun;

    psum_drain_4x1_if #(.OUT_W(8)) ob ();

    psum_drain_4x1 #(.ACC_W(32), .OUT_W(8), .SHIFT_W(5)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .capture_i   (capture_i),
        .bias_i      (bias_i),
        .shift_i     (shift_i),
        .after_sum_1 (after_sum_1),
        .after_sum_2 (after_sum_2),
        .after_sum_3 (after_sum_3),
        .after_sum_4 (after_sum_4),
        .clr_err_i   (clr_err_i),
        .busy        (busy),
        .overrun     (overrun),
        .ob          (ob)
    );

    always #5 CLK = ~CLK;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic held_valid = 1'b0;
    logic [7:0] held_data;
    logic [1:0] held_row;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives one capture (row k on edge E0+k) and queues its expected results.
    // dup_at adds an extra capture_i (optionally with clr_err_i) on that row's edge.
    task automatic apply_stimulus(input int bias, input int shift, input int s[4], input int e[4],
                                  input int dup_at, input logic dup_clr);
        exp_t x;
        for (int k = 0; k < 4; k++) begin
            x.data = 8'(e[k]);
            x.row  = 2'(k);
            x.last = (k == 3);
            exp_q.push_back(x);
        end
        for (int k = 0; k < 4; k++) begin
            capture_i   = (k == 0) || (k == dup_at);
            clr_err_i   = (k == dup_at) && dup_clr;
            bias_i      = (k == 0) ? bias : 32'sh0000_1234;
            shift_i     = (k == 0) ? 5'(shift) : 5'd0;
            after_sum_1 = 32'sd555555;
            after_sum_2 = 32'sd555555;
            after_sum_3 = 32'sd555555;
            after_sum_4 = 32'sd555555;
            case (k)
                0:       after_sum_1 = s[0];
                1:       after_sum_2 = s[1];
                2:       after_sum_3 = s[2];
                default: after_sum_4 = s[3];
            endcase
            if (k == 3) check_output("valid_before_latency", ob.out_valid, 0);
            step(1);
        end
        capture_i = 1'b0;
        clr_err_i = 1'b0;
        check_output("valid_at_latency", ob.out_valid, 1);
        check_output("busy_in_drain", busy, 1);
    endtask

    task automatic wait_drain(input int max_cycles);
        int i;
        i = 0;
        while (i < max_cycles && !(exp_q.size() == 0 && !ob.out_valid)) begin
            step(1);
            i++;
        end
        check_output("drain_done", (exp_q.size() == 0 && !ob.out_valid), 1);
        check_output("busy_after_drain", busy, 0);
    endtask

    task automatic pulse_clear();
        clr_err_i = 1'b1;
        step(1);
        clr_err_i = 1'b0;
        check_output("overrun_cleared", overrun, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_valid"},   ob.out_valid, 0);
        check_output({tag, "_data"},    ob.out_data, 0);
        check_output({tag, "_row"},     ob.out_row, 0);
        check_output({tag, "_last"},    ob.out_last, 0);
        check_output({tag, "_busy"},    busy, 0);
        check_output({tag, "_overrun"}, overrun, 0);
    endtask

    // Monitor: checks stall stability, then pops one expectation per handshake.
    always @(negedge CLK) begin
        if (!RSTN) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check_output("stall_valid", ob.out_valid, 1);
                check_output("stall_data", ob.out_data, held_data);
                check_output("stall_row", ob.out_row, held_row);
            end
            if (ob.out_valid && ob.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got row %0d data %0d, required no output",
                             ob.out_row, ob.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("out_row", ob.out_row, mon_e.row);
                    check_output("out_data", ob.out_data, mon_e.data);
                    check_output("out_last", ob.out_last, mon_e.last);
                end
            end
            held_valid = ob.out_valid && !ob.out_ready;
            held_data  = ob.out_data;
            held_row   = ob.out_row;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RSTN         = 1'b0;
        capture_i    = 1'b0;
        clr_err_i    = 1'b0;
        bias_i       = '0;
        shift_i      = '0;
        after_sum_1  = '0;
        after_sum_2  = '0;
        after_sum_3  = '0;
        after_sum_4  = '0;
        ob.out_ready = 1'b1;
        step(3);
        check_reset_outputs("reset");
        RSTN = 1'b1;
        step(2);

        // Basic: 300 and 400 saturate.
        apply_stimulus(0, 0, '{100, 200, 300, 400}, '{100, 200, 255, 255}, -1, 1'b0);
        wait_drain(20);

        // ReLU on negative t, saturation of 1024>>2=256, no wrap for max sum.
        apply_stimulus(-50, 2, '{-10, 50, 1074, 2147483647}, '{0, 0, 255, 255}, -1, 1'b0);
        wait_drain(20);

        // Max bias + max sum needs the extra bit: (2^32-2)>>31 = 1.
        apply_stimulus(2147483647, 31, '{2147483647, 1, 0, int'(32'h8000_0000)}, '{1, 1, 0, 0}, -1, 1'b0);
        wait_drain(20);

        apply_stimulus(7, 3, '{1, 9, 1000, 2041}, '{1, 2, 125, 255}, -1, 1'b0);
        wait_drain(20);

        // Backpressure: 5 stalled cycles, then ready 1,0,1,1,1.
        ob.out_ready = 1'b0;
        apply_stimulus(5, 1, '{10, 20, 30, 40}, '{7, 12, 17, 22}, -1, 1'b0);
        step(5);
        check_output("stall_queue_intact", exp_q.size(), 4);
        ob.out_ready = 1'b1; step(1);
        ob.out_ready = 1'b0; step(1);
        ob.out_ready = 1'b1; step(3);
        wait_drain(20);

        // Overrun: second capture while stalled in DRAIN must not disturb the bank.
        ob.out_ready = 1'b0;
        apply_stimulus(0, 0, '{1, 2, 3, 4}, '{1, 2, 3, 4}, -1, 1'b0);
        capture_i   = 1'b1;
        after_sum_1 = 32'sd99;
        after_sum_2 = 32'sd99;
        after_sum_3 = 32'sd99;
        after_sum_4 = 32'sd99;
        step(1);
        capture_i = 1'b0;
        check_output("overrun_in_drain", overrun, 1);
        check_output("drain_row_kept", ob.out_row, 0);
        ob.out_ready = 1'b1;
        wait_drain(20);
        check_output("overrun_sticky", overrun, 1);
        pulse_clear();

        // Clear and overrun together during CAPTURE: set wins.
        apply_stimulus(0, 0, '{11, 12, 13, 14}, '{11, 12, 13, 14}, 1, 1'b1);
        check_output("overrun_set_wins", overrun, 1);
        wait_drain(20);
        pulse_clear();

        // Capture coinciding with the final handshake is rejected.
        apply_stimulus(0, 0, '{5, 6, 7, 8}, '{5, 6, 7, 8}, -1, 1'b0);
        step(3);
        check_output("last_row_presented", ob.out_last, 1);
        capture_i = 1'b1;
        step(1);
        capture_i = 1'b0;
        check_output("overrun_at_final", overrun, 1);
        check_output("final_capture_not_busy", busy, 0);
        step(6);
        check_output("final_capture_no_valid", ob.out_valid, 0);
        pulse_clear();

        // Back-to-back: capture on the first IDLE cycle after the final handshake.
        apply_stimulus(0, 1, '{20, 40, 60, 80}, '{10, 20, 30, 40}, -1, 1'b0);
        step(4);
        apply_stimulus(3, 0, '{1, 2, 3, 4}, '{4, 5, 6, 7}, -1, 1'b0);
        wait_drain(20);
        check_output("b2b_no_overrun", overrun, 0);

        // Reset during CAPTURE after two rows, with overrun pending.
        capture_i   = 1'b1;
        after_sum_1 = 32'sd10;
        step(1);
        after_sum_2 = 32'sd20;
        step(1);
        capture_i = 1'b0;
        RSTN = 1'b0;
        #1;
        check_reset_outputs("rst_capture");
        step(2);
        RSTN = 1'b1;
        step(6);
        check_output("post_rst_capture_valid", ob.out_valid, 0);

        // Reset during DRAIN at rd_ptr=2.
        apply_stimulus(0, 0, '{1, 2, 3, 4}, '{1, 2, 3, 4}, -1, 1'b0);
        step(2);
        check_output("drain_rd_ptr_2", ob.out_row, 2);
        RSTN = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_drain");
        step(2);
        RSTN = 1'b1;
        step(6);
        check_output("post_rst_drain_valid", ob.out_valid, 0);

        apply_stimulus(0, 0, '{9, 8, 7, 6}, '{9, 8, 7, 6}, -1, 1'b0);
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
